// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and types for the fixed-point ALU and its arbiter
package alu_pkg;
    localparam int INT_W   = 7;
    localparam int FRAC_W  = 5;
    localparam int INST_W  = 3;
    localparam int DATA_W  = INT_W + FRAC_W;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [INST_W-1:0] OP_ADD = 3'b000;
    localparam logic [INST_W-1:0] OP_SUB = 3'b001;
    localparam logic [INST_W-1:0] OP_MUL = 3'b010;
    localparam logic [INST_W-1:0] OP_DIV = 3'b011;
    typedef logic req_id_t;
endpackage

// File: rtl/alu_tag_fifo.sv
// alu_tag_fifo: in-order FIFO of requester ids for ALU operations in flight
module alu_tag_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = MAX_OUT
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  req_id_t i_tag,
    input  logic    i_pop,
    output req_id_t o_head,
    output logic    o_empty,
    output logic    o_full
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic do_push, do_pop;
    assign o_empty = wr_q == rd_q;
    assign o_full  = (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]) && (wr_q[PTR_W-1] != rd_q[PTR_W-1]);
    assign o_head  = mem_q[rd_q[PTR_W-2:0]];
    // Pointer advance; a push at full is taken only when the head leaves in the same edge
    always_comb begin
        do_push = i_push && (!o_full || i_pop);
        do_pop  = i_pop && !o_empty;
        wr_d    = wr_q + PTR_W'(do_push);
        rd_d    = rd_q + PTR_W'(do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[PTR_W-2:0]] = i_tag;
    end
    // Pointer and tag storage registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with in-order result routing
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [DATA_W-1:0] i_req0_a,
    input  logic [DATA_W-1:0] i_req0_b,
    input  logic [INST_W-1:0] i_req0_inst,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [DATA_W-1:0] i_req1_a,
    input  logic [DATA_W-1:0] i_req1_b,
    input  logic [INST_W-1:0] i_req1_inst,
    output logic              o_alu_valid,
    output logic [DATA_W-1:0] o_alu_data_a,
    output logic [DATA_W-1:0] o_alu_data_b,
    output logic [INST_W-1:0] o_alu_inst,
    input  logic              i_alu_valid,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_alu_overflow,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    output logic              o_rsp0_overflow,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_data,
    output logic              o_rsp1_overflow,
    output logic              o_err
);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_id_t           last_q, last_d, winner, head;
    logic              slot, accept, ret, fifo_empty, fifo_full;
    logic              alu_valid_q, alu_valid_d, err_q, err_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [INST_W-1:0] alu_inst_q, alu_inst_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

    // A lone requester wins outright; a tie goes to whoever was not granted last
    assign winner       = (i_req0_valid ^ i_req1_valid) ? i_req1_valid : ~last_q;
    assign slot         = (cnt_q < CNT_MAX) && !fifo_full;
    assign o_req0_ready = slot && !winner;
    assign o_req1_ready = slot && winner;
    assign accept       = slot && (winner ? i_req1_valid : i_req0_valid);
    assign ret          = i_alu_valid && !fifo_empty;

    alu_tag_fifo #(.DEPTH(MAX_OUT)) u_tags (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (accept),
        .i_tag   (winner),
        .i_pop   (ret),
        .o_head  (head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    // Next-state: issue capture, outstanding count, response demux by head tag, sticky error
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(accept) - CNT_W'(ret);
        last_d      = accept ? winner : last_q;
        alu_valid_d = accept;
        alu_a_d     = accept ? (winner ? i_req1_a : i_req0_a) : alu_a_q;
        alu_b_d     = accept ? (winner ? i_req1_b : i_req0_b) : alu_b_q;
        alu_inst_d  = accept ? (winner ? i_req1_inst : i_req0_inst) : alu_inst_q;
        rsp_valid_d = {ret && head, ret && !head};
        rsp_ovf_d   = {rsp_valid_d[1] ? i_alu_overflow : rsp_ovf_q[1],
                       rsp_valid_d[0] ? i_alu_overflow : rsp_ovf_q[0]};
        rsp0_data_d = rsp_valid_d[0] ? i_alu_data : rsp0_data_q;
        rsp1_data_d = rsp_valid_d[1] ? i_alu_data : rsp1_data_q;
        err_d       = err_q || (i_alu_valid && cnt_q == '0);
    end

    // State registers; last resets to 1 so requester 0 wins the first tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            last_q      <= 1'b1;
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_inst_q  <= '0;
            rsp_valid_q <= '0;
            rsp_ovf_q   <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            alu_valid_q <= alu_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_inst_q  <= alu_inst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
            err_q       <= err_d;
        end
    end

    assign o_alu_valid     = alu_valid_q;
    assign o_alu_data_a    = alu_a_q;
    assign o_alu_data_b    = alu_b_q;
    assign o_alu_inst      = alu_inst_q;
    assign o_rsp0_valid    = rsp_valid_q[0];
    assign o_rsp1_valid    = rsp_valid_q[1];
    assign o_rsp0_overflow = rsp_ovf_q[0];
    assign o_rsp1_overflow = rsp_ovf_q[1];
    assign o_rsp0_data     = rsp0_data_q;
    assign o_rsp1_data     = rsp1_data_q;
    assign o_err           = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, routing, backpressure, overflow, errors and reset
module tb_alu_arbiter;
    import alu_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [INST_W-1:0] req0_inst = '0, req1_inst = '0;
    logic alu_valid, alu_rv, alu_ro;
    logic [DATA_W-1:0] alu_a, alu_b, alu_rd;
    logic [INST_W-1:0] alu_inst;
    logic rsp0_valid, rsp0_ovf, rsp1_valid, rsp1_ovf, err;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    int errors = 0, checks = 0;
    int lat = 3;
    logic spur_v = 1'b0;
    logic [DATA_W-1:0] spur_d = '0;
    logic pv [6];
    logic po [6];
    logic [DATA_W-1:0] pd [6];
    logic [DATA_W:0] exp0 [$];
    logic [DATA_W:0] exp1 [$];
    int grants [$];
    int acc_total = 0, rsp_total = 0, rsp0_n = 0, rsp1_n = 0;
    int n0, n1, rsp_cyc;
    logic acc0, acc1, saw1, seen;
    logic [8:0] alu_mask;
    logic [DATA_W:0] cap;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_inst(req0_inst),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_inst(req1_inst),
        .o_alu_valid(alu_valid), .o_alu_data_a(alu_a), .o_alu_data_b(alu_b), .o_alu_inst(alu_inst),
        .i_alu_valid(alu_rv), .i_alu_data(alu_rd), .i_alu_overflow(alu_ro),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_data(rsp0_data), .o_rsp0_overflow(rsp0_ovf),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_data(rsp1_data), .o_rsp1_overflow(rsp1_ovf),
        .o_err(err)
    );

    // Q7.5 add with overflow when the true sum leaves the signed 12-bit range
    function automatic logic [DATA_W:0] add_q(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return {s[DATA_W] != s[DATA_W-1], s[DATA_W-1:0]};
    endfunction

    // In-order ALU model with latency lat, reset together with the arbiter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                pv[i] <= 1'b0;
                po[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= alu_valid;
            {po[0], pd[0]} <= add_q(alu_a, alu_b);
            for (int i = 1; i < 6; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign alu_rv = spur_v | pv[lat-1];
    assign alu_rd = spur_v ? spur_d : pd[lat-1];
    assign alu_ro = spur_v ? 1'b0 : po[lat-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response scoreboard: each requester must see its own results in issue order
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (rsp0_valid) begin
                rsp0_n++;
                rsp_total++;
                if (exp0.size() == 0) check("rsp0_unexpected", 1, 0);
                else check("rsp0_result", {rsp0_ovf, rsp0_data}, exp0.pop_front());
            end
            if (rsp1_valid) begin
                rsp1_n++;
                rsp_total++;
                if (exp1.size() == 0) check("rsp1_unexpected", 1, 0);
                else check("rsp1_result", {rsp1_ovf, rsp1_data}, exp1.pop_front());
            end
        end
    end

    task automatic drive(input logic v0, input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] b0, input logic [INST_W-1:0] i0,
                         input logic v1, input logic [DATA_W-1:0] a1, input logic [DATA_W-1:0] b1, input logic [INST_W-1:0] i1);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_inst = i0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_inst = i1;
        #1;
        acc0 = v0 && req0_ready;
        acc1 = v1 && req1_ready;
        if (acc0) begin exp0.push_back(add_q(a0, b0)); grants.push_back(0); end
        if (acc1) begin exp1.push_back(add_q(a1, b1)); grants.push_back(1); end
        acc_total += int'(acc0) + int'(acc1);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_drain(input int max);
        for (int c = 0; c < max && acc_total != rsp_total; c++) idle();
        check("drain", acc_total - rsp_total, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_outs", {alu_valid, alu_a, alu_b, alu_inst, rsp0_valid, rsp0_data, rsp0_ovf,
                           rsp1_valid, rsp1_data, rsp1_ovf, err}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b10);
        exp0.delete();
        exp1.delete();
        grants.delete();
        acc_total = 0; rsp_total = 0; rsp0_n = 0; rsp1_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Single request, latency 3
        lat = 3;
        drive(1'b1, 12'h030, 12'h048, OP_ADD, 1'b0, '0, '0, '0);
        check("t1_accept", acc0, 1);
        alu_mask = '0; rsp_cyc = -1; saw1 = 1'b0; cap = '0;
        for (int i = 1; i <= 8; i++) begin
            idle();
            alu_mask[i] = alu_valid;
            if (rsp0_valid && rsp_cyc < 0) begin rsp_cyc = i; cap = {rsp0_ovf, rsp0_data}; end
            if (rsp1_valid) saw1 = 1'b1;
        end
        check("t1_issue_cycles", alu_mask, 9'b000000010);
        check("t1_issue_ops", {alu_a, alu_b, alu_inst}, {12'h030, 12'h048, 3'b000});
        check("t1_rsp_cycle", rsp_cyc, 5);
        check("t1_rsp_data", cap, 13'h0078);
        check("t1_rsp1_quiet", saw1, 0);
        // Both requesters every cycle, latency 1
        do_reset();
        lat = 1; n0 = 0; n1 = 0;
        for (int c = 0; c < 40 && (n0 < 8 || n1 < 8); c++) begin
            drive(n0 < 8, 12'(n0 + 1), 12'h020, OP_ADD, n1 < 8, 12'(12'h100 + n1), 12'h040, OP_ADD);
            n0 += int'(acc0);
            n1 += int'(acc1);
        end
        check("t2_issued", (n0 << 8) | n1, 16'h0808);
        check("t2_grant_total", grants.size(), 16);
        for (int i = 0; i < 16 && i < grants.size(); i++) check("t2_grant", grants[i], i % 2);
        wait_drain(20);
        check("t2_rsp_counts", (rsp0_n << 8) | rsp1_n, 16'h0808);
        // Backpressure, latency 6, req0 continuous
        do_reset();
        lat = 6; n0 = 0;
        for (int i = 0; i <= 12; i++) begin
            drive(1'b1, 12'(n0 * 4), 12'h001, OP_ADD, 1'b0, '0, '0, '0);
            check("t3_ready", req0_ready, (i < 4) || (i >= 8 && i < 12));
            n0 += int'(acc0);
        end
        check("t3_accepts", n0, 8);
        wait_drain(30);
        // Overflow passes data through
        lat = 3;
        drive(1'b1, 12'h7E0, 12'h7E0, OP_ADD, 1'b0, '0, '0, '0);
        check("t4_accept", acc0, 1);
        seen = 1'b0; cap = '0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle();
            if (rsp0_valid) begin seen = 1'b1; cap = {rsp0_ovf, rsp0_data}; end
        end
        check("t4_rsp_seen", seen, 1);
        check("t4_ovf_data", cap, 13'h1FC0);
        idle();
        check("t4_hold", {rsp0_valid, rsp0_ovf, rsp0_data}, 14'h1FC0);
        wait_drain(10);
        // Spurious ALU result with nothing outstanding
        @(negedge clk);
        spur_v = 1'b1; spur_d = 12'h123;
        @(negedge clk);
        spur_v = 1'b0;
        #1;
        check("t5_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        check("t5_err", err, 1);
        repeat (3) idle();
        check("t5_err_held", err, 1);
        // Reset with three operations in flight
        do_reset();
        lat = 6;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b1, 12'(12'h040 + i), 12'h010, OP_ADD);
        do_reset();
        drive(1'b0, '0, '0, '0, 1'b1, 12'h0A0, 12'h020, 3'b101);
        check("t6_accept", acc1, 1);
        idle();
        check("t6_issue", {alu_valid, alu_inst, alu_a}, {1'b1, 3'b101, 12'h0A0});
        wait_drain(20);
        check("t6_rsp_counts", (rsp0_n << 8) | rsp1_n, 1);
        check("t6_rsp1_data", rsp1_data, 12'h0C0);
        check("t6_err_clear", err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
